i2c_cfg_arb: RTL

I2C_CFG_ARB -- requirements
Module: i2c_cfg_arb

---
 rtl/i2c_cfg_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_arb.sv
// Three-channel arbiter in front of a single I2C master: boot channel 0 has fixed priority,
// runtime channels 1/2 alternate on ties and are gated by init_done. Each command is timed out.
module i2c_cfg_arb #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    input  logic        req2,
    input  logic [15:0] data2,
    input  logic        init_done,
    input  logic        i2c_done,
    output logic        i2c_exec,
    output logic [15:0] i2c_data,
    output logic        ack0,
    output logic        ack1,
    output logic        ack2,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  grant;
    logic        rr_fav2;
    logic [15:0] wait_cnt;
    logic [2:0]  ack;

    logic [2:0]  req_vec;
    logic [2:0]  pend;
    logic [2:0]  clr;
    logic [15:0] hold     [3];
    logic [15:0] data_vec [3];

    logic        elig1;
    logic        elig2;
    logic        gnt_valid;
    logic        gnt_tie;
    logic [1:0]  gnt_idx;
    logic [15:0] sel_data;

    assign req_vec     = {req2, req1, req0};
    assign data_vec[0] = data0;
    assign data_vec[1] = data1;
    assign data_vec[2] = data2;

    assign clr[0] = (state == DONE) && (grant == 2'd0);
    assign clr[1] = (state == DONE) && (grant == 2'd1);
    assign clr[2] = (state == DONE) && (grant == 2'd2);

    // A request landing in the cycle its own flag clears is a fresh capture, not a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                hold[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (req_vec[k] && (!pend[k] || clr[k])) begin
                    pend[k] <= 1'b1;
                    hold[k] <= data_vec[k];
                end else if (clr[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    assign elig1 = pend[1] && init_done;
    assign elig2 = pend[2] && init_done;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_tie   = 1'b0;
        gnt_idx   = 2'd0;
        if (pend[0]) begin
            gnt_valid = 1'b1;
        end else if (elig1 && elig2) begin
            gnt_valid = 1'b1;
            gnt_tie   = 1'b1;
            gnt_idx   = rr_fav2 ? 2'd2 : 2'd1;
        end else if (elig1) begin
            gnt_valid = 1'b1;
            gnt_idx   = 2'd1;
        end else if (elig2) begin
            gnt_valid = 1'b1;
            gnt_idx   = 2'd2;
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd1:    sel_data = hold[1];
            2'd2:    sel_data = hold[2];
            default: sel_data = hold[0];
        endcase
    end

    // The round-robin pointer only moves when a 1-vs-2 tie is actually resolved,
    // so a lone runtime request never disturbs the alternation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 2'd0;
            rr_fav2  <= 1'b0;
            wait_cnt <= 16'd0;
            i2c_exec <= 1'b0;
            i2c_data <= 16'h0000;
            ack      <= 3'b000;
            err      <= 1'b0;
        end else begin
            i2c_exec <= 1'b0;
            ack      <= 3'b000;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state    <= ISSUE;
                        grant    <= gnt_idx;
                        i2c_data <= sel_data;
                        i2c_exec <= 1'b1;
                        if (gnt_tie) begin
                            rr_fav2 <= (gnt_idx == 2'd1);
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= 16'd0;
                end
                WAIT: begin
                    if (i2c_done) begin
                        state <= DONE;
                        ack   <= 3'b001 << grant;
                    end else if (wait_cnt == TIMEOUT - 16'd1) begin
                        state <= DONE;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ack0 = ack[0];
    assign ack1 = ack[1];
    assign ack2 = ack[2];
    assign busy = (|pend) || (state != IDLE);

endmodule
